// File: rtl/cache_req_frontend.sv
// Request queue + single-outstanding cache probe FSM with refill on read miss.
// Keeps saturating hit/miss probe statistics.
module cache_req_frontend #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             req_write,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      cache_address,
  output logic             cache_is_write,
  output logic [31:0]      cache_write_data,
  input  logic             cache_hit,
  input  logic [31:0]      cache_read_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_hit,
  output logic             rsp_write,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE, ISSUE, REFILL, RESP
  } state_e;

  state_e state_q, state_d;

  logic [31:0] fa_q [DEPTH];
  logic        fw_q [DEPTH];
  logic [31:0] fd_q [DEPTH];

  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;

  logic [31:0] h_addr_q, h_wdata_q;
  logic        h_write_q;
  logic [31:0] rdata_q;
  logic        hit_q;
  logic [CNT_W-1:0] hits_q, miss_q;

  logic full, empty, push, pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign req_ready = !reset && !full;
  assign push  = req_valid && req_ready;
  assign pop   = (state_q == IDLE) && !empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = (h_write_q || cache_hit) ? RESP : REFILL;
      REFILL:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Queue storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= req_addr;
      fw_q[wp_q] <= req_write;
      fd_q[wp_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      h_addr_q  <= '0;
      h_write_q <= 1'b0;
      h_wdata_q <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      hits_q    <= '0;
      miss_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
      if (pop) begin
        h_addr_q  <= fa_q[rp_q];
        h_write_q <= fw_q[rp_q];
        h_wdata_q <= fd_q[rp_q];
      end
      if (state_q == ISSUE) begin
        hit_q   <= cache_hit;
        rdata_q <= h_write_q ? 32'h0 : cache_read_data;
        if (cache_hit) begin
          if (hits_q != '1) hits_q <= hits_q + CNT_W'(1);
        end else begin
          if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        end
      end
      if (state_q == REFILL) rdata_q <= cache_read_data;
    end
  end

  // Address stays on the last issued request between probes.
  assign cache_address    = h_addr_q;
  assign cache_is_write   = (state_q == ISSUE) && h_write_q;
  assign cache_write_data = (state_q == ISSUE) ? h_wdata_q : 32'h0;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_hit    = hit_q;
  assign rsp_write  = h_write_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign hit_count  = hits_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_req_frontend.sv
// Bench for cache_req_frontend: behavioural cache, shadow model, scoreboard.
// Counter width is narrowed so saturation is reachable in a short run.
module tb_cache_req_frontend;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_write = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic [31:0]   cache_address;
  logic          cache_is_write;
  logic [31:0]   cache_write_data;
  logic          cache_hit;
  logic [31:0]   cache_read_data;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_hit;
  logic          rsp_write;
  logic          busy;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_req_frontend #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .cache_address(cache_address), .cache_is_write(cache_is_write),
    .cache_write_data(cache_write_data),
    .cache_hit(cache_hit), .cache_read_data(cache_read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_write(rsp_write),
    .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural cache: word array, written flags, present (hit) flags.
  logic [31:0] mem  [1024];
  bit          wr   [1024];
  bit          pres [1024];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic        pl_pres = 1'b0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr[11:2]]  <= pl_data;
      wr[pl_addr[11:2]]   <= 1'b1;
      pres[pl_addr[11:2]] <= pl_pres;
    end
    if (cache_is_write) begin
      mem[cache_address[11:2]]  <= cache_write_data;
      wr[cache_address[11:2]]   <= 1'b1;
      pres[cache_address[11:2]] <= 1'b1;
    end
  end

  assign cache_hit = pres[cache_address[11:2]];
  assign cache_read_data = wr[cache_address[11:2]] ?
                           mem[cache_address[11:2]] : pat(cache_address);

  // Shadow model, updated in request order at acceptance time.
  logic [31:0] m_mem  [1024];
  bit          m_wr   [1024];
  bit          m_pres [1024];
  int          m_hits = 0;
  int          m_miss = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        write;
  } exp_t;
  exp_t sbq[$];

  task automatic preload(input logic [31:0] a, input logic [31:0] d,
                         input logic p);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d; pl_pres = p;
    @(posedge clk); #1;
    pl_en = 1'b0;
    m_mem[a[11:2]] = d; m_wr[a[11:2]] = 1'b1; m_pres[a[11:2]] = p;
  endtask

  task automatic push_req(input logic [31:0] a, input logic w,
                          input logic [31:0] d);
    exp_t e;
    bit acc;
    acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL push_timeout: addr %h not accepted, want accepted", a);
    end else begin
      e.hit = m_pres[a[11:2]];
      e.write = w;
      if (w) begin
        e.rdata = 32'h0;
        m_mem[a[11:2]] = d; m_wr[a[11:2]] = 1'b1; m_pres[a[11:2]] = 1'b1;
      end else begin
        e.rdata = m_wr[a[11:2]] ? m_mem[a[11:2]] : pat(a);
      end
      if (e.hit) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
      else       m_miss = (m_miss < 15) ? m_miss + 1 : 15;
      sbq.push_back(e);
    end
  endtask

  // Waits (bounded) for a response handshake and returns its fields.
  task automatic get_rsp(output logic [31:0] rd, output logic h,
                         output logic w, output bit ok);
    ok = 0; rd = '0; h = 1'b0; w = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid && rsp_ready) begin
        rd = rsp_rdata; h = rsp_hit; w = rsp_write; ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++;
      $display("FAIL rst_ready: got %b want 0", req_ready); end
    total++;
    if ({rsp_valid, busy, cache_is_write} !== 3'b000) begin bad++;
      $display("FAIL rst_flags: got %b want 000",
               {rsp_valid, busy, cache_is_write}); end
    total++;
    if ({hit_count, miss_count} !== '0) begin bad++;
      $display("FAIL rst_counts: got %h/%h want 0/0",
               hit_count, miss_count); end
    total++;
    if ({cache_address, rsp_rdata} !== 64'h0) begin bad++;
      $display("FAIL rst_data: got %h %h want 0 0",
               cache_address, rsp_rdata); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++;
      $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read_hit;
    exp_t e; logic [31:0] rd; logic h, w; bit ok;
    logic [3:0] seen;
    preload(32'h40, 32'hA5A5_A5A5, 1'b1);
    rsp_ready = 1'b0;
    push_req(32'h40, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); seen[i] = rsp_valid;
    end
    total++;
    if (seen[2:0] !== 3'b100) begin bad++;
      $display("FAIL hit_latency: got %b want 100", seen[2:0]); end
    rsp_ready = 1'b1;
    get_rsp(rd, h, w, ok);
    e = sbq.pop_front();
    total++;
    if (!ok || rd !== e.rdata || h !== e.hit || w !== e.write) begin bad++;
      $display("FAIL hit_rsp: got ok=%0d %h h%b w%b want %h h%b w%b",
               ok, rd, h, w, e.rdata, e.hit, e.write); end
    total++;
    if (hit_count !== CW'(m_hits)) begin bad++;
      $display("FAIL hit_count: got %0d want %0d", hit_count, m_hits); end
  endtask

  task automatic test_read_miss;
    exp_t e; logic [31:0] rd; logic h, w; bit ok;
    logic [3:0] seen;
    preload(32'h80, 32'h1234_5678, 1'b0);
    rsp_ready = 1'b0;
    push_req(32'h80, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); seen[i] = rsp_valid;
    end
    total++;
    if (seen !== 4'b1000) begin bad++;
      $display("FAIL miss_latency: got %b want 1000", seen); end
    rsp_ready = 1'b1;
    get_rsp(rd, h, w, ok);
    e = sbq.pop_front();
    total++;
    if (!ok || rd !== e.rdata || h !== e.hit || w !== e.write) begin bad++;
      $display("FAIL miss_rsp: got ok=%0d %h h%b w%b want %h h%b w%b",
               ok, rd, h, w, e.rdata, e.hit, e.write); end
    total++;
    if (miss_count !== CW'(m_miss)) begin bad++;
      $display("FAIL miss_count: got %0d want %0d", miss_count, m_miss); end
  endtask

  task automatic test_store_load;
    exp_t e; logic [31:0] rd; logic h, w; bit ok;
    rsp_ready = 1'b0;
    push_req(32'h100, 1'b1, 32'hDEAD_BEEF);
    push_req(32'h100, 1'b0, 32'h0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      get_rsp(rd, h, w, ok);
      e = sbq.pop_front();
      total++;
      if (!ok || rd !== e.rdata || h !== e.hit || w !== e.write) begin
        bad++;
        $display("FAIL st_ld_rsp%0d: got ok=%0d %h h%b w%b want %h h%b w%b",
                 i, ok, rd, h, w, e.rdata, e.hit, e.write);
      end
    end
    total++;
    if (hit_count !== CW'(m_hits) || miss_count !== CW'(m_miss)) begin
      bad++;
      $display("FAIL st_ld_counts: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, m_hits, m_miss);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; logic [31:0] rd; logic h, w; bit ok;
    bit stuck;
    preload(32'h304, 32'hCAFE_F00D, 1'b1);
    rsp_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      push_req(32'h300 + 32'(i * 4), (i == 2), 32'h1000 + 32'(i));
    @(negedge clk);
    total++;
    if ({req_ready, busy, rsp_valid} !== 3'b011) begin bad++;
      $display("FAIL bp_full: got rdy/busy/vld %b want 011",
               {req_ready, busy, rsp_valid}); end
    stuck = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) stuck = 0;
    end
    total++;
    if (!stuck) begin bad++;
      $display("FAIL bp_hold: req_ready rose, want held at 0"); end
    rsp_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      get_rsp(rd, h, w, ok);
      e = sbq.pop_front();
      total++;
      if (!ok || rd !== e.rdata || h !== e.hit || w !== e.write) begin
        bad++;
        $display("FAIL bp_rsp%0d: got ok=%0d %h h%b w%b want %h h%b w%b",
                 i, ok, rd, h, w, e.rdata, e.hit, e.write);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++;
      $display("FAIL bp_drain: busy got %b want 0", busy); end
    total++;
    if (hit_count !== CW'(m_hits) || miss_count !== CW'(m_miss)) begin
      bad++;
      $display("FAIL bp_counts: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, m_hits, m_miss);
    end
  endtask

  task automatic test_reset_refill;
    bit any;
    rsp_ready = 1'b1;
    push_req(32'h200, 1'b0, 32'h0);
    push_req(32'h40, 1'b0, 32'h0);
    @(posedge clk); #1;
    total++;
    if (cache_address !== 32'h200 || cache_is_write !== 1'b0 ||
        rsp_valid !== 1'b0) begin bad++;
      $display("FAIL refill_probe: got %h w%b v%b want 00000200 w0 v0",
               cache_address, cache_is_write, rsp_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, busy, req_ready} !== 3'b000) begin bad++;
      $display("FAIL abort_flags: got vld/busy/rdy %b want 000",
               {rsp_valid, busy, req_ready}); end
    total++;
    if ({hit_count, miss_count} !== '0) begin bad++;
      $display("FAIL abort_counts: got %0d/%0d want 0/0",
               hit_count, miss_count); end
    sbq.delete();
    m_hits = 0; m_miss = 0;
    reset = 1'b0;
    any = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) any = 1;
    end
    total++;
    if (any || req_ready !== 1'b1) begin bad++;
      $display("FAIL abort_quiet: activity=%0d rdy=%b want 0 1",
               any, req_ready); end
  endtask

  task automatic test_saturation;
    exp_t e; logic [31:0] rd; logic h, w; bit ok;
    int errs;
    errs = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_req(32'h40, 1'b0, 32'h0);
      get_rsp(rd, h, w, ok);
      e = sbq.pop_front();
      if (!ok || rd !== e.rdata || h !== e.hit) errs++;
    end
    total++;
    if (errs != 0) begin bad++;
      $display("FAIL sat_rsp: got %0d bad responses want 0", errs); end
    total++;
    if (hit_count !== 4'hF || hit_count !== CW'(m_hits)) begin bad++;
      $display("FAIL sat_hits: got %0d want 15", hit_count); end
    total++;
    if (miss_count !== CW'(m_miss)) begin bad++;
      $display("FAIL sat_miss: got %0d want %0d", miss_count, m_miss); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_store_load();
    test_back_to_back();
    test_reset_refill();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
